clk_div_prog: RTL and testbench

//   Runtime-programmable integer clock divider, any N in [2, 2^DIV_W-1], odd or even,

---
 rtl/clk_div_prog.sv | 89 ++++++++
 tb/tb_clk_div_prog.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty integer divider (N in [2, 2^DIV_W-1]); clk_out/tick follow cnt with one flop of delay.
// Single pending-divisor slot: a load while busy is dropped, and a load with div_val<2 is rejected with div_err.
module clk_div_prog #(
    parameter int DIV_W   = 8,
    parameter int DIV_RST = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             div_busy,
    output logic             div_done,
    output logic             div_err,
    output logic [DIV_W-1:0] div_active,
    output logic             tick,
    output logic             clk_out
);

    localparam logic [DIV_W-1:0] N_RST = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] pend_val;
    logic [DIV_W-1:0] n_nxt;
    logic [DIV_W:0]   h_nxt;
    logic             at_end;
    logic             apply;
    logic             accept;
    logic             reject;
    logic             q_p;
    logic             q_n;

    // at_end covers both the running boundary cycle and the idle hold state
    always_comb begin
        at_end  = (cnt == div_active - ONE);
        apply   = at_end && div_busy;
        accept  = div_load && !div_busy && (div_val >= TWO);
        reject  = div_load && !div_busy && (div_val < TWO);
        n_nxt   = apply ? pend_val : div_active;
        h_nxt   = ({1'b0, n_nxt} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        cnt_nxt = cnt + ONE;
        if (at_end) begin
            cnt_nxt = en ? '0 : (n_nxt - ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= N_RST - ONE;
            div_active <= N_RST;
            pend_val   <= '0;
            div_busy   <= 1'b0;
            div_done   <= 1'b0;
            div_err    <= 1'b0;
            tick       <= 1'b0;
            q_p        <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            div_active <= n_nxt;
            div_done   <= apply;
            div_err    <= reject;
            tick       <= at_end && en;
            q_p        <= ({1'b0, cnt_nxt} < h_nxt);
            if (accept) begin
                pend_val <= div_val;
            end
            if (apply) begin
                div_busy <= 1'b0;
            end else if (accept) begin
                div_busy <= 1'b1;
            end
        end
    end

    // Half-cycle delayed copy trims the odd-N high phase to exactly N/2 cycles
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_n <= 1'b0;
        end else begin
            q_n <= q_p;
        end
    end

    assign clk_out = div_active[0] ? (q_p & q_n) : q_p;

endmodule

// File: tb/tb_clk_div_prog.sv
// Randomised and directed checks of clk_div_prog against a period/position model.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] div_val = 8'd0;
    logic       div_load = 1'b0;
    logic       div_busy, div_done, div_err, tick, clk_out;
    logic [7:0] div_active;

    int n_chk = 0;
    int n_fail = 0;

    // Model: m_pos is the cycle index inside the current period, -1 when idle
    int m_pos, m_n, m_pend;
    bit m_busy, m_done, m_err;

    clk_div_prog #(.DIV_W(8), .DIV_RST(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
        .div_busy(div_busy), .div_done(div_done), .div_err(div_err),
        .div_active(div_active), .tick(tick), .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = -1; m_n = 3; m_pend = 0; m_busy = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit busy_old;
        busy_old = m_busy;
        m_done = 0;
        m_err = 0;
        if (m_pos < 0 || m_pos == m_n - 1) begin
            if (busy_old) begin
                m_n = m_pend; m_busy = 0; m_done = 1;
            end
            m_pos = en ? 0 : -1;
        end else begin
            m_pos++;
        end
        if (div_load && !busy_old) begin
            if (div_val >= 2) begin
                m_pend = div_val; m_busy = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    // h counts half-cycles from the start of the period
    function automatic bit exp_clk(input int h);
        if (m_pos < 0) return 1'b0;
        if (m_n % 2 == 0) return h < m_n;
        return (h >= 1) && (h <= m_n);
    endfunction

    task automatic compare_all(input int h);
        chk("clk_out", clk_out, exp_clk(h));
        chk("tick", tick, (m_pos == 0) ? 1 : 0);
        chk("div_busy", div_busy, m_busy);
        chk("div_done", div_done, m_done);
        chk("div_err", div_err, m_err);
        chk("div_active", div_active, m_n);
    endtask

    initial model_reset();

    always begin
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        #1;
        compare_all(2 * m_pos);
    end

    always begin
        @(negedge clk);
        #1;
        compare_all(2 * m_pos + 1);
    end

    task automatic drive_slot();
        @(negedge clk);
        #2;
    endtask

    task automatic load(input int v);
        drive_slot();
        div_val = 8'(v);
        div_load = 1'b1;
        drive_slot();
        div_load = 1'b0;
    endtask

    task automatic wait_level(input logic v, input string name);
        for (int i = 0; i < 6000; i++) begin
            if (clk_out == v) return;
            #1;
        end
        chk({name, "_timeout"}, clk_out, v);
    endtask

    task automatic measure(input int per, input int high, input string name);
        time t0, t1, t2;
        drive_slot();
        wait_level(1'b0, name);
        wait_level(1'b1, name);
        t0 = $time;
        wait_level(1'b0, name);
        t1 = $time;
        wait_level(1'b1, name);
        t2 = $time;
        chk({name, "_high"}, int'(t1 - t0), high);
        chk({name, "_period"}, int'(t2 - t0), per);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (div_done) return;
        end
        chk({name, "_done_timeout"}, div_done, 1);
    endtask

    initial begin
        #12;
        chk("rst_clk_out", clk_out, 0);
        chk("rst_active", div_active, 3);
        chk("rst_busy", div_busy, 0);
        chk("rst_tick", tick, 0);
        en = 1'b1;
        drive_slot();
        rst_n = 1'b1;

        measure(30, 15, "n3");
        chk("n3_active", div_active, 3);

        load(5);
        wait_done("n5");
        measure(50, 25, "n5");

        load(4);   wait_done("n4");   measure(40, 20, "n4");
        load(2);   wait_done("n2");   measure(20, 10, "n2");
        load(255); wait_done("n255"); measure(2550, 1275, "n255");
        chk("n255_active", div_active, 255);

        load(0);
        load(1);
        chk("err_active", div_active, 255);
        load(3);
        load(7);
        wait_done("busy_ign");
        chk("busy_ign_active", div_active, 3);
        repeat (4) @(posedge clk);
        chk("busy_ign_idle", div_busy, 0);

        load(5);
        wait_done("en_n5");
        drive_slot();
        wait_level(1'b1, "en_drop");
        en = 1'b0;
        repeat (12) drive_slot();
        chk("idle_low", clk_out, 0);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("restart_pos", clk_out, 0);
        chk("restart_tick", tick, 1);
        @(negedge clk);
        #1;
        chk("restart_rise5", clk_out, 1);
        measure(50, 25, "resume");

        load(3);
        drive_slot();
        wait_level(1'b1, "rst_mid");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_clk", clk_out, 0);
        chk("rst_mid_busy", div_busy, 0);
        drive_slot();
        rst_n = 1'b1;
        measure(30, 15, "after_rst");

        for (int c = 0; c < 1500; c++) begin
            drive_slot();
            div_load = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                int r;
                r = $urandom_range(0, 15);
                div_val = (r < 2) ? 8'(r) : 8'($urandom_range(2, 12));
                div_load = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
                drive_slot();
                rst_n = 1'b1;
            end
        end
        div_load = 1'b0;
        drive_slot();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
